// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial pattern-scan controller: FSM encoding and
// default geometry of the word, pattern and hit counter.
package seq_scan_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_W     = 8;
  localparam int DEF_PLEN  = 4;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_PLEN-1:0] DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_scan_ctrl_match.sv
// Overlapping pattern detector: keeps the last PLEN-1 stream bits and compares
// them, together with the current bit, against PATTERN.
module pattern_match
  import seq_scan_pkg::*;
#(
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic shift_en_i,
  input  logic bit_i,
  output logic match_o
);

  logic [PLEN-2:0] hist_q, hist_d;
  logic [PLEN-1:0] window;

  // Oldest history bit lands in the MSB, matching the first-received-bit-in-MSB pattern.
  assign window  = {hist_q, bit_i};
  assign match_o = (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    if (clear_i) begin
      hist_d = '0;
    end else if (shift_en_i) begin
      hist_d = window[PLEN-2:0];
    end
  end

  // NOTE: sequential state is only ever written with <= so every register
  // samples the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts words over valid/ready, serializes them MSB-first,
// and counts pattern hits across the whole frame.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int              W       = DEF_W,
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
  parameter int              CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             word_valid,
  input  logic [W-1:0]     word_data,
  input  logic             word_last,
  output logic             word_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             hit_pulse,
  output logic [CNT_W-1:0] hit_count,
  output logic             done
);

  localparam int BC_W = $clog2(W);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     sr_q, sr_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic             last_q, last_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;

  logic in_shift, frame_start, accept, last_bit, match;

  assign in_shift    = (state_q == ST_SHIFT);
  assign frame_start = (state_q == ST_IDLE) && start;
  assign accept      = (state_q == ST_WAIT) && word_valid && !abort;
  assign last_bit    = (bit_cnt_q == BC_W'(W - 1));

  pattern_match #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_match (
    .clk        (clk),
    .rst_n      (rst),
    .clear_i    (frame_start),
    .shift_en_i (in_shift),
    .bit_i      (bit_out),
    .match_o    (match)
  );

  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    last_d      = last_q;
    hit_count_d = hit_count_q;
    hit_pulse_d = in_shift && match;

    // Hit registration is independent of abort so the aborted cycle's bit still counts.
    if (hit_pulse_d && (hit_count_q != {CNT_W{1'b1}})) begin
      hit_count_d = hit_count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WAIT;
          hit_count_d = '0;
          last_d      = 1'b0;
        end
      end
      ST_WAIT: begin
        if (accept) begin
          sr_d      = word_data;
          last_d    = word_last;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d      = {sr_q[W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          state_d = last_q ? ST_DONE : ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      last_q      <= 1'b0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      last_q      <= last_d;
      hit_pulse_q <= hit_pulse_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign word_ready = (state_q == ST_WAIT);
  assign busy       = (state_q != ST_IDLE);
  assign bit_valid  = in_shift;
  assign bit_out    = in_shift & sr_q[W-1];
  assign done       = (state_q == ST_DONE);
  assign hit_pulse  = hit_pulse_q;
  assign hit_count  = hit_count_q;

endmodule
